// File: rtl/joyserial_pkg.sv
// Shared constants and helpers for the serial joystick reader.
// Frame layout: LOAD_SLOT, lead slots, then W sampled slots (the last one also transfers).
package joyserial_pkg;

  localparam int LOAD_SLOT      = 0;
  localparam int DEF_LEAD_SLOTS = 2;

  typedef enum logic [1:0] {
    SLOT_LOAD,
    SLOT_LEAD,
    SLOT_SAMPLE,
    SLOT_LAST
  } slot_class_e;

  function automatic int joy_width(input int num_joys, input int bits_per_joy);
    return num_joys * bits_per_joy;
  endfunction

  function automatic int frame_slots(input int lead_slots, input int width);
    return lead_slots + width;
  endfunction

  function automatic int first_sample_slot(input int lead_slots);
    return lead_slots;
  endfunction

  // Player 0 sits in the most significant field because it is shifted in first.
  function automatic int joy_field_lsb(input int p, input int num_joys = 2,
                                       input int bits_per_joy = 12);
    return (num_joys - p - 1) * bits_per_joy;
  endfunction

endpackage

// File: rtl/joyserial_tick.sv
// Free-running divider producing the chain shift clock and a one-clk enable
// on the clk edge where joy_clk rises.
module joyserial_tick
  import joyserial_pkg::*;
#(
  parameter int DIV_LOG2 = 5
) (
  input  logic clk,
  input  logic rst,
  output logic joy_clk,
  output logic tick
);

  localparam logic [DIV_LOG2-1:0] TICK_DIV = {1'b0, {(DIV_LOG2-1){1'b1}}};

  logic [DIV_LOG2-1:0] div_q;
  logic [DIV_LOG2-1:0] div_d;

  always_comb begin
    div_d = div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign joy_clk = div_q[DIV_LOG2-1];
  assign tick    = (div_q == TICK_DIV);

endmodule

// File: rtl/joyserial_reader.sv
// Serial joystick reader for daisy-chained 74HC165-style registers; joy_out updates atomically per frame.
// Optional feature: define JOYSERIAL_DEBOUNCE_EN to require each bit to match across two frames.
module joyserial_reader
  import joyserial_pkg::*;
#(
  parameter int NUM_JOYS     = 2,
  parameter int BITS_PER_JOY = 12,
  parameter int DIV_LOG2     = 5,
  parameter int LEAD_SLOTS   = DEF_LEAD_SLOTS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             joy_data,
  input  logic                             hold,
  output logic                             joy_clk,
  output logic                             joy_load,
  output logic [NUM_JOYS*BITS_PER_JOY-1:0] joy_out,
  output logic                             frame_done
);

  localparam int W      = joy_width(NUM_JOYS, BITS_PER_JOY);
  localparam int FRAME  = frame_slots(LEAD_SLOTS, W);
  localparam int SLOT_W = $clog2(FRAME);

  localparam logic [SLOT_W-1:0] LOAD_SLOT_V  = SLOT_W'(LOAD_SLOT);
  localparam logic [SLOT_W-1:0] FIRST_SMP_V  = SLOT_W'(first_sample_slot(LEAD_SLOTS));
  localparam logic [SLOT_W-1:0] LAST_SLOT_V  = SLOT_W'(FRAME - 1);

  logic tick;

  joyserial_tick #(
    .DIV_LOG2(DIV_LOG2)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .joy_clk(joy_clk),
    .tick   (tick)
  );

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [W-1:0]      shadow_q, shadow_d;
  logic [W-1:0]      joy_out_q, joy_out_d;
  logic              joy_load_q, joy_load_d;
  logic              frame_done_q, frame_done_d;
  slot_class_e       slot_cls;
`ifdef JOYSERIAL_DEBOUNCE_EN
  logic [W-1:0]      prev_q, prev_d;
  logic [W-1:0]      stable;
`endif

  always_comb begin
    if (slot_q == LOAD_SLOT_V) begin
      slot_cls = SLOT_LOAD;
    end else if (slot_q == LAST_SLOT_V) begin
      slot_cls = SLOT_LAST;
    end else if (slot_q >= FIRST_SMP_V) begin
      slot_cls = SLOT_SAMPLE;
    end else begin
      slot_cls = SLOT_LEAD;
    end
  end

  // The transfer sees shadow_d so the final sample lands in joy_out on its own edge.
  always_comb begin
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    joy_out_d    = joy_out_q;
    joy_load_d   = joy_load_q;
    frame_done_d = 1'b0;
`ifdef JOYSERIAL_DEBOUNCE_EN
    prev_d       = prev_q;
    stable       = '0;
`endif
    if (tick) begin
      slot_d     = (slot_cls == SLOT_LAST) ? '0 : slot_q + 1'b1;
      joy_load_d = (slot_cls != SLOT_LOAD);
      if (slot_cls == SLOT_SAMPLE || slot_cls == SLOT_LAST) begin
        shadow_d = {shadow_q[W-2:0], joy_data};
      end
      if (slot_cls == SLOT_LAST) begin
`ifdef JOYSERIAL_DEBOUNCE_EN
        stable = ~(shadow_d ^ prev_q);
        prev_d = shadow_d;
        if (!hold) begin
          joy_out_d    = (joy_out_q & ~stable) | (shadow_d & stable);
          frame_done_d = 1'b1;
        end
`else
        if (!hold) begin
          joy_out_d    = shadow_d;
          frame_done_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= '0;
      shadow_q     <= '1;
      joy_out_q    <= '1;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef JOYSERIAL_DEBOUNCE_EN
      prev_q       <= '1;
`endif
    end else begin
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      joy_out_q    <= joy_out_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
`ifdef JOYSERIAL_DEBOUNCE_EN
      prev_q       <= prev_d;
`endif
    end
  end

  assign joy_load   = joy_load_q;
  assign joy_out    = joy_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joyserial_reader.sv
// Bench for joyserial_reader: default instance (2x12, DIV_LOG2=5) and a 4x8, DIV_LOG2=3 instance.
// A frame-level model predicts every output each cycle; literal checks pin frame timing and words.
module tb_joyserial_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] jd;
  logic [1:0] hd;

  logic        clk_a, load_a, done_a;
  logic [23:0] out_a;
  logic        clk_b, load_b, done_b;
  logic [31:0] out_b;

  joyserial_reader u_a (
    .clk       (clk),
    .rst       (rst),
    .joy_data  (jd[0]),
    .hold      (hd[0]),
    .joy_clk   (clk_a),
    .joy_load  (load_a),
    .joy_out   (out_a),
    .frame_done(done_a)
  );

  joyserial_reader #(
    .NUM_JOYS    (4),
    .BITS_PER_JOY(8),
    .DIV_LOG2    (3),
    .LEAD_SLOTS  (2)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .joy_data  (jd[1]),
    .hold      (hd[1]),
    .joy_clk   (clk_b),
    .joy_load  (load_b),
    .joy_out   (out_b),
    .frame_done(done_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: edges since reset release, expected outputs, debounce history.
  int          n[2];
  logic [31:0] e_out[2];
  logic [31:0] e_prev[2];
  logic        e_done[2];

  function automatic int cf_w(input int c);     return (c == 0) ? 24 : 32; endfunction
  function automatic int cf_p(input int c);     return (c == 0) ? 32 : 8;  endfunction
  function automatic int cf_h(input int c);     return cf_p(c) / 2;        endfunction
  function automatic int cf_fr(input int c);    return cf_w(c) + 2;        endfunction
  function automatic logic [31:0] cf_mask(input int c);
    return (c == 0) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Word presented by the chain during frame f (counted from reset release).
  function automatic logic [31:0] word_of(input int c, input int f);
    logic [31:0] w;
    if (c == 0) begin
      case (f)
        0, 2:    w = 32'hFFFFFF;
        1:       w = 32'hDFFFFF;
        3, 4:    w = 32'h5A3C96;
        default: w = 32'h0F0F0F ^ 32'(f * 7);
      endcase
    end else begin
      case (f)
        0, 1:    w = 32'hA53CFF00;
        default: w = 32'h9E3779B9 ^ 32'(f * 32'h01010101);
      endcase
    end
    return w & cf_mask(c);
  endfunction

  function automatic logic hold_of(input int c, input int f);
    return (c == 0) ? (f == 3) : (f == 5);
  endfunction

  function automatic logic exp_load(input int c);
    if (n[c] < cf_h(c)) return 1'b1;
    return (((n[c] - cf_h(c)) / cf_p(c)) % cf_fr(c)) != 0;
  endfunction

  function automatic logic exp_clk(input int c);
    return (n[c] % cf_p(c)) >= cf_h(c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clk cycle: drive inputs for the next edge, advance the model at the edge,
  // compare on the falling edge.
  task automatic step();
    int m, k, slot, f;
    logic [31:0] w, msk;
    for (int c = 0; c < 2; c++) begin
      m = n[c] + 1;
      jd[c] = 1'($urandom_range(0, 1));
      hd[c] = 1'($urandom_range(0, 1));
      if (m >= cf_h(c) && ((m - cf_h(c)) % cf_p(c)) == 0) begin
        k    = (m - cf_h(c)) / cf_p(c);
        slot = k % cf_fr(c);
        f    = k / cf_fr(c);
        w    = word_of(c, f);
        if (slot >= 2) jd[c] = w[cf_w(c) - 1 - (slot - 2)];
        if (slot == cf_fr(c) - 1) hd[c] = hold_of(c, f);
      end
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        n[c] = 0;
        e_out[c] = cf_mask(c);
        e_prev[c] = cf_mask(c);
        e_done[c] = 1'b0;
      end else begin
        n[c]++;
        e_done[c] = 1'b0;
        if (n[c] >= cf_h(c) && ((n[c] - cf_h(c)) % cf_p(c)) == 0) begin
          k = (n[c] - cf_h(c)) / cf_p(c);
          if ((k % cf_fr(c)) == cf_fr(c) - 1) begin
            f = k / cf_fr(c);
            w = word_of(c, f);
`ifdef JOYSERIAL_DEBOUNCE_EN
            msk = ~(w ^ e_prev[c]) & cf_mask(c);
            e_prev[c] = w;
`else
            msk = cf_mask(c);
`endif
            if (!hold_of(c, f)) begin
              e_out[c]  = (e_out[c] & ~msk) | (w & msk);
              e_done[c] = 1'b1;
            end
          end
        end
      end
    end
    @(negedge clk);
    check("a_joy_out",    {8'h0, out_a},  e_out[0]);
    check("a_frame_done", 32'(done_a),    32'(e_done[0]));
    check("a_joy_load",   32'(load_a),    32'(exp_load(0)));
    check("a_joy_clk",    32'(clk_a),     32'(exp_clk(0)));
    check("b_joy_out",    out_b,          e_out[1]);
    check("b_frame_done", 32'(done_b),    32'(e_done[1]));
    check("b_joy_load",   32'(load_b),    32'(exp_load(1)));
    check("b_joy_clk",    32'(clk_b),     32'(exp_clk(1)));
  endtask

  // Steps until the chosen instance pulses frame_done; reports edges since reset release.
  task automatic wait_done(input int c, input int exp_t, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      if ((c == 0) ? done_a : done_b) seen = 1'b1;
    end
    check(name, seen ? 32'(n[c]) : 32'hFFFF_FFFF, 32'(exp_t));
  endtask

  initial begin
    rst = 1'b1;
    jd  = 2'b11;
    hd  = 2'b00;
    for (int c = 0; c < 2; c++) begin
      n[c] = 0; e_out[c] = cf_mask(c); e_prev[c] = cf_mask(c); e_done[c] = 1'b0;
    end
    @(negedge clk);
    repeat (3) step();
    check("rst_a_out",  {8'h0, out_a}, 32'h00FFFFFF);
    check("rst_a_load", 32'(load_a),   32'd1);
    check("rst_a_clk",  32'(clk_a),    32'd0);
    check("rst_a_done", 32'(done_a),   32'd0);
    check("rst_b_out",  out_b,         32'hFFFFFFFF);
    rst = 1'b0;

    // 4x8 chain: 34-slot frame of 8 clk slots.
    wait_done(1, 268, "b_first_done_time");
    wait_done(1, 540, "b_second_done_time");
    check("b_pattern", out_b, 32'hA53CFF00);

    // Default chain: 26-slot frames of 32 clk.
    wait_done(0, 816, "a_first_done_time");
    check("a_frame0_out", {8'h0, out_a}, 32'h00FFFFFF);
    wait_done(0, 1648, "a_frame1_done_time");
`ifdef JOYSERIAL_DEBOUNCE_EN
    check("a_glitch_out", {8'h0, out_a}, 32'h00FFFFFF);
`else
    check("a_slot4_out",  {8'h0, out_a}, 32'h00DFFFFF);
`endif
    wait_done(0, 2480, "a_frame2_done_time");
    check("a_frame2_out", {8'h0, out_a}, 32'h00FFFFFF);
    // Frame 3 ends under hold: the next pulse must be frame 4's.
    wait_done(0, 4144, "a_hold_skip_time");
    check("a_after_hold", {8'h0, out_a}, 32'h005A3C96);

    // Reset in the middle of slot 12 of frame 5.
    while (n[0] < 4570) step();
    rst = 1'b1;
    step();
    check("mid_rst_out",  {8'h0, out_a}, 32'h00FFFFFF);
    check("mid_rst_done", 32'(done_a),   32'd0);
    check("mid_rst_load", 32'(load_a),   32'd1);
    check("mid_rst_clk",  32'(clk_a),    32'd0);
    rst = 1'b0;
    wait_done(0, 816, "a_post_rst_done_time");
    check("a_post_rst_out", {8'h0, out_a}, 32'h00FFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/joyserial_reader.md
# joyserial_reader

Parametrised serial joystick reader for daisy-chained 74HC165-style shift registers. Generates the shift-register load/clock pair, samples the serial stream into a shadow register, and updates all player outputs atomically once per frame, so a frame is never delivered partially. Sits between the joystick connector pins and the core's input mapping logic. It replaces fixed two-player, fixed-order decoding with a generic N-player, B-bit word.

## Interface
Parameters:
- NUM_JOYS, 2, number of chained controllers
- BITS_PER_JOY, 12, bits per controller
- DIV_LOG2, 5, joy_clk period = 2^DIV_LOG2 clk cycles (must be ≥ 2)
- LEAD_SLOTS, 2, idle slots per frame before the first sampled bit (must be ≥ 2)

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- joy_data  in  1  serial data from the chain, active-low buttons
- hold  in  1  when 1 at frame end, the finished frame is discarded
- joy_clk  out  1  shift clock to the chain
- joy_load  out  1  parallel-load strobe to the chain, active-low
- joy_out  out  NUM_JOYS*BITS_PER_JOY  raw button word, 1 = released
- frame_done  out  1  one-clk pulse when joy_out has been updated

## Operation
- W = NUM_JOYS*BITS_PER_JOY. FRAME = LEAD_SLOTS + W slots.
- Divider `div` is DIV_LOG2 bits and free-running. joy_clk = div[DIV_LOG2-1].
- `tick` = (div == 2^(DIV_LOG2-1) - 1). It is an internal enable, not a derived clock, so all logic stays on clk.
- Slot counter `slot`, range 0..FRAME-1, advances on each tick and wraps from FRAME-1 to 0.
- Each tick, the pre-increment `slot` value selects the action:
  - slot == 0: joy_load <= 0.
  - Any other slot: joy_load <= 1.
  - LEAD_SLOTS ≤ slot < FRAME: shadow <= {shadow[W-2:0], joy_data}. The first sampled bit ends at shadow[W-1], which is player 0's MSB.
  - slot == FRAME-1 (last sample): the transfer is evaluated at the same tick, using the shadow value that includes this sample.
- Transfer when hold == 0: joy_out <= shadow, frame_done <= 1 for one clk.
- Transfer when hold == 1: joy_out is unchanged and there is no frame_done pulse. Sampling of the next frame is unaffected.
- Player p occupies joy_out[(NUM_JOYS-p)*BITS_PER_JOY-1 -: BITS_PER_JOY].
- No bit remapping is done; the mapping layer assigns meaning to bits.

## Timing
- Reset values: div = 0, slot = 0, shadow = all 1, joy_out = all 1, joy_load = 1, joy_clk = 0, frame_done = 0.
- First tick after reset occurs 2^(DIV_LOG2-1) clk cycles after rst deasserts.
- joy_load is low for exactly one joy_clk period (2^DIV_LOG2 clk) per frame.
- Samples are taken on the clk edge where joy_clk rises.
- Frame period = FRAME * 2^DIV_LOG2 clk. With defaults, 26*32 = 832 clk.
- Latency from the last sampled bit to joy_out update: 0 clk, since both happen on the same edge. frame_done is asserted in the following cycle, coincident with the new joy_out value.
- rst mid-frame: everything returns to reset values and the partial shadow is discarded. joy_out reads all-released until a full frame completes.
- hold toggling mid-frame has no effect; it is examined only at the transfer tick.

## Configuration
- JOYSERIAL_DEBOUNCE_EN defined: a `prev` register (reset to all 1) is added.
  - At each transfer tick, prev <= shadow, regardless of hold.
  - Each joy_out bit updates only when shadow bit == prev bit, i.e. the value is stable for two consecutive frames.
  - frame_done pulses as usual.
- JOYSERIAL_DEBOUNCE_EN undefined: joy_out <= shadow directly and no prev register exists.

## Structure
- Package joyserial_pkg holds:
  - localparam helpers for W and FRAME.
  - function joy_field_lsb(p) returning the LSB index of player p.
  - Slot-class constants (LOAD_SLOT, first sample slot).
- Sub-module joyserial_tick contains the divider, joy_clk and tick generation, parametrised by DIV_LOG2.
- The top level contains the slot counter, shadow, transfer and debounce logic.

## Test plan
- Default params, joy_data constant 1 → joy_load low for 32 clk every 832 clk; joy_out = 24'hFFFFFF; frame_done pulses every 832 clk.
- Drive joy_data = 0 only during the third sampled slot (slot 4) → joy_out = 24'hDFFFFF after the frame; next frame with all 1 → 24'hFFFFFF.
- NUM_JOYS=4, BITS_PER_JOY=8, DIV_LOG2=3, pattern A5,3C,FF,00 serialised MSB first → joy_out = 32'hA53CFF00; frame = 34 slots = 272 clk.
- hold=1 across a frame end with a new pattern → joy_out keeps the old value, no frame_done; release hold → the next frame updates joy_out.
- Assert rst at slot 12 → all outputs return to reset values next clk; the first frame_done arrives 16 + 25*32 clk after rst deasserts.
- JOYSERIAL_DEBOUNCE_EN, a bit glitches to 0 for one frame only → joy_out bit stays 1; held at 0 for two frames → bit goes 0 on the second transfer.
